// File: rtl/bcd_countdown_n.sv
// N-digit BCD down-counter with stored preset, one-shot/auto-reload mode, hold,
// digit sanitising and registered expiry/reload pulses.
module bcd_countdown_n #(
   parameter int NUM_DIGITS          = 2,
   parameter bit AUTO_RELOAD_DEFAULT = 1'b0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    reconfig,
   input  logic [4*NUM_DIGITS-1:0] setDigits,
   input  logic                    reset_timer,
   input  logic                    decrement,
   input  logic                    hold,
   input  logic                    mode_wr,
   input  logic                    mode_in,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic                    do_not_borrow,
   output logic                    expired,
   output logic                    reloaded
);

   localparam int W = 4 * NUM_DIGITS;

   logic [W-1:0] preset_q, preset_d;
   logic [W-1:0] count_q, count_d;
   logic [W-1:0] count_dec_s;
   logic         mode_q, mode_d;
   logic         expired_q, expired_d;
   logic         reloaded_q, reloaded_d;

   // Clamp every nibble above 9 to 9 so the preset is always valid BCD.
   function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (v[4*k +: 4] > 4'd9) begin
            r[4*k +: 4] = 4'd9;
         end
      end
      return r;
   endfunction

   // Ripple-borrow BCD decrement across all digits in one step.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (borrow) begin
            if (v[4*k +: 4] == 4'd0) begin
               r[4*k +: 4] = 4'd9;
            end else begin
               r[4*k +: 4] = v[4*k +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign count_dec_s = bcd_dec(count_q);

   always_comb begin
      preset_d   = preset_q;
      count_d    = count_q;
      mode_d     = mode_q;
      expired_d  = 1'b0;
      reloaded_d = 1'b0;

      if (reconfig) begin
         preset_d = sanitize(setDigits);
         count_d  = sanitize(setDigits);
      end else if (reset_timer) begin
         count_d = preset_q;
      end else if (decrement && !hold) begin
         if (count_q == '0) begin
            // At zero: auto-reload restarts from the preset, one-shot saturates.
            if (mode_q) begin
               count_d    = preset_q;
               reloaded_d = 1'b1;
            end else begin
               count_d = count_q;
            end
         end else begin
            count_d   = count_dec_s;
            expired_d = (count_dec_s == '0);
         end
      end else begin
         count_d = count_q;
      end

      if (mode_wr) begin
         mode_d = mode_in;
      end else begin
         mode_d = mode_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         preset_q   <= '0;
         count_q    <= '0;
         mode_q     <= AUTO_RELOAD_DEFAULT;
         expired_q  <= 1'b0;
         reloaded_q <= 1'b0;
      end else begin
         preset_q   <= preset_d;
         count_q    <= count_d;
         mode_q     <= mode_d;
         expired_q  <= expired_d;
         reloaded_q <= reloaded_d;
      end
   end

   assign digits        = count_q;
   assign do_not_borrow = |count_q;
   assign expired       = expired_q;
   assign reloaded      = reloaded_q;

endmodule
